// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the unified-memory arbiter.
// The arbiter sits on the slave modport; requesters and the memory model
// sit on the master modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  // Data load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  // Fixed-latency synchronous memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency synchronous memory between the instruction-fetch
// port and the data load/store port. Data wins arbitration unless fetch has
// been passed over STARVE_MAX times in a row. Misaligned data accesses are
// answered with d_err without touching memory.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [3:0]    WAIT_LOAD  = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic              owner_d_q;   // 1 = data port owns the transaction
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-3:0] addr_q;      // word address; byte offset is never driven out
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        wait_q;
  logic [SW-1:0]     starve_q;

  logic grant_d, grant_i, misaligned;

  // Fetch byte offset is irrelevant: fetches are always word accesses.
  logic unused_fetch_offset;
  assign unused_fetch_offset = ^bus.i_addr[1:0];

  assign grant_d    = bus.d_req && (!bus.i_req || (starve_q < STARVE_LIM));
  assign grant_i    = !grant_d && bus.i_req;
  assign misaligned = (bus.d_addr[1:0] != 2'b00);

  // State register; reset drops the FSM straight back to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d)      state_d = misaligned ? ACK : ISSUE;
        else if (grant_i) state_d = ISSUE;
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_q == 4'd0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait counter, read-data capture and starvation counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wait_q    <= '0;
      starve_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            owner_d_q <= 1'b1;
            addr_q    <= bus.d_addr[ADDR_W-1:2];
            we_q      <= bus.d_we;
            wdata_q   <= bus.d_wdata;
            err_q     <= misaligned;
            rdata_q   <= '0;
            // Only consecutive data wins while fetch waits count toward starvation.
            if (!bus.i_req)               starve_q <= '0;
            else if (starve_q < STARVE_LIM) starve_q <= starve_q + 1'b1;
          end else if (grant_i) begin
            owner_d_q <= 1'b0;
            addr_q    <= bus.i_addr[ADDR_W-1:2];
            we_q      <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            starve_q  <= '0;
          end
        end
        ISSUE: wait_q <= WAIT_LOAD;
        WAIT: begin
          if (wait_q == 4'd0) rdata_q <= we_q ? '0 : bus.mem_rdata;
          else                wait_q  <= wait_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state so reset clears them without waiting for a clock.
  always_comb begin
    bus.mem_en    = (state_q == ISSUE);
    bus.mem_we    = (state_q == ISSUE) && we_q;
    bus.mem_addr  = (state_q == ISSUE) ? {addr_q, 2'b00} : '0;
    bus.mem_wdata = (state_q == ISSUE) ? wdata_q : '0;
    bus.i_ack     = (state_q == ACK) && !owner_d_q;
    bus.d_ack     = (state_q == ACK) && owner_d_q;
    bus.i_rdata   = bus.i_ack ? rdata_q : '0;
    bus.d_rdata   = bus.d_ack ? rdata_q : '0;
    bus.d_err     = bus.d_ack && err_q;
    busy          = (state_q != IDLE);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single unified memory (the `Memory_0` instance in the datapath) between two requesters: the instruction-fetch port and the data load/store port.
- Serialises requests and arbitrates with data priority plus a starvation guard for fetch.
- Drives a fixed-latency synchronous memory.
- Returns read data to the owning requester with a one-cycle acknowledge pulse.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.
- LATENCY, 1, cycles from the mem_en cycle until mem_rdata is valid; legal values 1..15.
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch byte address.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_rdata  out  DATA_W  fetched word; valid while i_ack=1.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_W  load data; valid while d_ack=1; 0 for stores and errors.
- d_err  out  1  misaligned access; valid with d_ack.
- mem_en  out  1  memory access strobe, exactly one cycle per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0]=0).
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  memory read data, valid LATENCY cycles after the mem_en cycle.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0, state to IDLE, starvation counter to 0, latched request discarded.
- Reset mid-transaction: mem_en and mem_we drop immediately (asynchronously). No ack is ever issued for the aborted request.
- State IDLE:
  - No request pending: stay in IDLE.
  - Arbitration rule:
    - Grant data if d_req=1 and (i_req=0 or starve_cnt < STARVE_MAX).
    - Otherwise grant fetch if i_req=1.
  - On a grant, latch owner, address, we and wdata.
  - Data grant with d_addr[1:0] != 0: go to ACK with err=1. No memory access is made.
  - Any other grant: go to ISSUE.
- Starvation counter:
  - Increments on a data grant while i_req=1.
  - Clears on a fetch grant, or on a data grant while i_req=0.
  - Saturates at STARVE_MAX.
- State ISSUE (1 cycle):
  - mem_en=1; mem_we = latched we (always 0 for fetch).
  - mem_addr = latched address with bits [1:0] forced to 0; mem_wdata = latched wdata.
  - Load wait counter with LATENCY-1, then go to WAIT.
- State WAIT:
  - All mem_* outputs are 0.
  - Decrement the counter each cycle.
  - When the counter is 0, capture mem_rdata into the owner's rdata register (capture 0 for stores) and go to ACK.
- State ACK (1 cycle):
  - Owner's ack=1 with rdata (and d_err when the owner is data); the non-owner's ack stays 0.
  - Next state is IDLE.
- Requester handshake: the requester deasserts req at the clock edge where it samples ack=1. The following IDLE cycle therefore sees a fresh req value.
- Latency:
  - req sampled in IDLE at cycle T -> ack at T+2+LATENCY (T+3 at the default).
  - Misaligned data access -> d_ack at T+1.
- Stability: request inputs are ignored outside IDLE. Changes to the address or data inputs after the grant have no effect.
- ack exclusivity: i_ack and d_ack are never 1 in the same cycle.
- Back-to-back throughput: one access per LATENCY+3 cycles.

Test Plan:
- Reset, then fetch i_addr=0x4 with memory word 0x20100009 at address 0x4 (LATENCY=1) -> mem_en at T+1 with mem_addr=0x4 and mem_we=0; i_ack at T+3 with i_rdata=0x20100009; busy=1 in cycles T+1..T+3.
- Simultaneous i_req and d_req, store d_addr=0x10, d_wdata=0xDEADBEEF -> data granted first (mem_we=1, mem_addr=0x10, d_ack with d_rdata=0); fetch acked in the next transaction; a subsequent load of 0x10 returns 0xDEADBEEF.
- d_req held continuously with successive loads and i_req held, STARVE_MAX=4 -> exactly 4 d_acks, then one i_ack; counter clears; pattern repeats.
- Load d_addr=0x13 -> d_ack at T+1 with d_err=1 and d_rdata=0; mem_en never asserted.
- LATENCY=3, load of 0x8 -> mem_en at T+1; mem_rdata sampled at T+4; d_ack at T+5.
- Assert reset during WAIT -> all outputs 0 immediately; no ack for the aborted request; after release, a new fetch completes normally with the counter at 0.
